// File: rtl/pll_mdrp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_mdrp_ctrl
// Purpose  : Upstream controller for the GW5A PLLA dynamic-reconfiguration
//            (MDRP) port. Turns single host requests (write / read / apply)
//            into MDRP opcode sequences and returns a one-cycle completion.
//            "Apply" pulses the PLL reset, then waits for lock with a timeout.
//            Everything runs on mdclk.
// Ports    : mdclk, reset          - clock (also PLL MDCLK), async active-high
//            req_*                 - host request (op/addr/wdata, valid/ready)
//            rsp_*                 - completion pulse, read data, error flag
//            busy, lock_lost       - status (lock_lost is sticky)
//            pll_reset, pll_lock   - PLL reset out, asynchronous lock in
//            mdopc/mdainc/mdwdi    - MDRP command outputs
//            mdrdo                 - MDRP read data input
// Revision : 1.0 - initial release
// ============================================================================
module pll_mdrp_ctrl #(
    parameter int RD_LATENCY   = 1,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       lock_lost,
    output logic       pll_reset,
    input  logic       pll_lock,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo
);

    // Request opcodes
    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;
    localparam logic [1:0] c_OP_APPLY = 2'b10;

    // MDRP opcodes
    localparam logic [1:0] c_MD_NOP   = 2'b00;
    localparam logic [1:0] c_MD_WRITE = 2'b01;
    localparam logic [1:0] c_MD_READ  = 2'b10;
    localparam logic [1:0] c_MD_ADDR  = 2'b11;

    // Counter widths; a parameter of 1 still needs a 1-bit counter
    localparam int c_RD_W   = (RD_LATENCY   > 1) ? $clog2(RD_LATENCY)   : 1;
    localparam int c_RST_W  = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int c_LOCK_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [c_RD_W-1:0]   c_RD_LAST   = c_RD_W'(RD_LATENCY - 1);
    localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_WR        = 3'd2,
        S_RD        = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_RST       = 3'd5,
        S_LOCK_WAIT = 3'd6,
        S_RESP      = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [7:0]          r_wdata;
    logic [c_RD_W-1:0]   r_rd_cnt;
    logic [c_RST_W-1:0]  r_rst_cnt;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic                r_lock_meta;
    logic                r_lock_s;
    logic                r_lock_s_d;

    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [7:0]          r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic                r_lock_lost;
    logic                r_pll_reset;
    logic [1:0]          r_mdopc;
    logic [7:0]          r_mdwdi;

    logic                w_accept;
    logic [1:0]          w_mdopc_nxt;
    logic [7:0]          w_mdwdi_nxt;
    logic                w_err_nxt;
    logic                w_capture;
    logic                w_lock_ok;
    logic                w_lock_fall;

    assign w_accept    = req_valid & r_req_ready;
    // Lock loss is only meaningful while idle; during apply the PLL is
    // deliberately reset and lock is expected to drop.
    assign w_lock_fall = (r_state == S_IDLE) & r_lock_s_d & ~r_lock_s;

    // Next state plus the MDRP command that the next state will present.
    // Outputs are registered from these next-state values so they line up
    // with the state they belong to.
    always_comb begin
        w_state_nxt = r_state;
        w_mdopc_nxt = c_MD_NOP;
        w_mdwdi_nxt = 8'h00;
        w_err_nxt   = 1'b0;
        w_capture   = 1'b0;
        w_lock_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        c_OP_WRITE, c_OP_READ: begin
                            w_state_nxt = S_ADDR;
                            w_mdopc_nxt = c_MD_ADDR;
                            w_mdwdi_nxt = req_addr;
                        end
                        c_OP_APPLY: w_state_nxt = S_RST;
                        default: begin
                            w_state_nxt = S_RESP;
                            w_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (r_op == c_OP_WRITE) begin
                    w_state_nxt = S_WR;
                    w_mdopc_nxt = c_MD_WRITE;
                    w_mdwdi_nxt = r_wdata;
                end else begin
                    w_state_nxt = S_RD;
                    w_mdopc_nxt = c_MD_READ;
                end
            end
            S_WR:      w_state_nxt = S_RESP;
            S_RD:      w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                // Last wait cycle is the one where mdrdo is valid
                if (r_rd_cnt == c_RD_LAST) begin
                    w_state_nxt = S_RESP;
                    w_capture   = 1'b1;
                end
            end
            S_RST: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt = S_LOCK_WAIT;
                end
            end
            S_LOCK_WAIT: begin
                // Lock is checked first so lock on the terminal cycle wins
                if (r_lock_s) begin
                    w_state_nxt = S_RESP;
                    w_lock_ok   = 1'b1;
                end else if (r_lock_cnt == c_LOCK_LAST) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_wdata     <= 8'h00;
            r_rd_cnt    <= '0;
            r_rst_cnt   <= '0;
            r_lock_cnt  <= '0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_lock_s_d  <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_pll_reset <= 1'b0;
            r_mdopc     <= 2'b00;
            r_mdwdi     <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_lock_s_d  <= r_lock_s;

            if (w_accept) begin
                r_op    <= req_op;
                r_wdata <= req_wdata;
            end

            // Counters clear whenever their state is left, so they never wrap
            if (r_state == S_RD_WAIT && w_state_nxt == S_RD_WAIT)
                r_rd_cnt <= r_rd_cnt + 1'b1;
            else
                r_rd_cnt <= '0;

            if (r_state == S_RST && w_state_nxt == S_RST)
                r_rst_cnt <= r_rst_cnt + 1'b1;
            else
                r_rst_cnt <= '0;

            if (r_state == S_LOCK_WAIT && w_state_nxt == S_LOCK_WAIT)
                r_lock_cnt <= r_lock_cnt + 1'b1;
            else
                r_lock_cnt <= '0;

            if (w_capture)
                r_rsp_rdata <= mdrdo;

            // Set has priority over clear
            if (w_lock_fall)
                r_lock_lost <= 1'b1;
            else if (w_lock_ok)
                r_lock_lost <= 1'b0;

            r_req_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_rsp_err   <= w_err_nxt;
            r_pll_reset <= (w_state_nxt == S_RST);
            r_mdopc     <= w_mdopc_nxt;
            r_mdwdi     <= w_mdwdi_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;
    assign lock_lost = r_lock_lost;
    assign pll_reset = r_pll_reset;
    assign mdopc     = r_mdopc;
    assign mdainc    = 1'b0;
    assign mdwdi     = r_mdwdi;

endmodule
`default_nettype wire

// File: tb/tb_pll_mdrp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_mdrp_ctrl
// Purpose  : Directed self-checking bench for pll_mdrp_ctrl (default params).
//            Inputs change on the falling edge; outputs are sampled there.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_mdrp_ctrl;

    localparam int c_RDL = 1;

    logic       mdclk     = 1'b0;
    logic       reset     = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op    = 2'b00;
    logic [7:0] req_addr  = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       lock_lost;
    logic       pll_reset;
    logic       pll_lock  = 1'b0;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;

    int n_checks = 0;
    int n_fail   = 0;

    pll_mdrp_ctrl u_dut (
        .mdclk     (mdclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .lock_lost (lock_lost),
        .pll_reset (pll_reset),
        .pll_lock  (pll_lock),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo)
    );

    always #5 mdclk = ~mdclk;

    // MDRP read model: data valid RD_LATENCY cycles after the READ opcode
    logic [3:0] rd_pipe = 4'h0;
    always @(posedge mdclk) rd_pipe <= {rd_pipe[2:0], (mdopc == 2'b10)};
    assign mdrdo = rd_pipe[c_RDL-1] ? 8'hC3 : 8'hEE;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, drives one request, returns at the
    // falling edge of cycle 1. With hold=1 req_valid is left asserted.
    task automatic start_req(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] wdata, input bit hold);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge mdclk);
            n++;
        end
        if (req_ready !== 1'b1) check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge mdclk);
        if (!hold) req_valid = 1'b0;
    endtask

    // lock_delay < 0: lock never returns, a timeout error is expected
    task automatic apply_run(input int lock_delay);
        int hi = 0;
        start_req(2'b10, 8'h00, 8'h00, 1'b0);
        pll_lock = 1'b0;
        while (pll_reset === 1'b1 && hi < 40) begin
            hi++;
            @(negedge mdclk);
        end
        check("apply_rst_len", hi, 16);
        if (lock_delay >= 0) begin
            repeat (lock_delay) @(negedge mdclk);
            pll_lock = 1'b1;
            @(negedge mdclk);
            @(negedge mdclk);
            check("apply_rsp_early", {31'd0, rsp_valid}, 32'd0);
            @(negedge mdclk);
            check("apply_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("apply_rsp_err", {31'd0, rsp_err}, 32'd0);
        end else begin
            repeat (4095) @(negedge mdclk);
            check("timeout_early", {31'd0, rsp_valid}, 32'd0);
            @(negedge mdclk);
            check("timeout_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("timeout_rsp_err", {31'd0, rsp_err}, 32'd1);
        end
        @(negedge mdclk);
        check("apply_end_valid", {31'd0, rsp_valid}, 32'd0);
        check("apply_end_err", {31'd0, rsp_err}, 32'd0);
        check("apply_end_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        // ---------------- reset state ----------------
        @(negedge mdclk);
        @(negedge mdclk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pll_reset", {31'd0, pll_reset}, 32'd0);
        check("rst_mdopc", {30'd0, mdopc}, 32'd0);
        check("rst_mdwdi", {24'd0, mdwdi}, 32'd0);
        check("rst_lock_lost", {31'd0, lock_lost}, 32'd0);
        reset = 1'b0;
        @(negedge mdclk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // ---------------- write 0x12 <= 0x5A ----------------
        start_req(2'b00, 8'h12, 8'h5A, 1'b0);
        check("wr_c1_mdopc", {30'd0, mdopc}, 32'd3);
        check("wr_c1_mdwdi", {24'd0, mdwdi}, 32'h12);
        check("wr_c1_busy", {31'd0, busy}, 32'd1);
        check("wr_c1_ready", {31'd0, req_ready}, 32'd0);
        check("wr_mdainc", {31'd0, mdainc}, 32'd0);
        @(negedge mdclk);
        check("wr_c2_mdopc", {30'd0, mdopc}, 32'd1);
        check("wr_c2_mdwdi", {24'd0, mdwdi}, 32'h5A);
        @(negedge mdclk);
        check("wr_c3_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_c3_err", {31'd0, rsp_err}, 32'd0);
        check("wr_c3_mdopc", {30'd0, mdopc}, 32'd0);
        @(negedge mdclk);
        check("wr_c4_ready", {31'd0, req_ready}, 32'd1);
        check("wr_c4_valid", {31'd0, rsp_valid}, 32'd0);
        check("wr_c4_busy", {31'd0, busy}, 32'd0);

        // ---------------- read 0x07 ----------------
        start_req(2'b01, 8'h07, 8'h00, 1'b0);
        check("rd_c1_mdopc", {30'd0, mdopc}, 32'd3);
        check("rd_c1_mdwdi", {24'd0, mdwdi}, 32'h07);
        @(negedge mdclk);
        check("rd_c2_mdopc", {30'd0, mdopc}, 32'd2);
        check("rd_c2_mdwdi", {24'd0, mdwdi}, 32'h00);
        @(negedge mdclk);
        check("rd_c3_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge mdclk);
        check("rd_c4_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_c4_rdata", {24'd0, rsp_rdata}, 32'hC3);
        check("rd_c4_err", {31'd0, rsp_err}, 32'd0);
        @(negedge mdclk);

        // ---------------- reserved op ----------------
        start_req(2'b11, 8'h55, 8'hAA, 1'b0);
        check("rsv_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsv_err", {31'd0, rsp_err}, 32'd1);
        check("rsv_mdopc", {30'd0, mdopc}, 32'd0);
        check("rsv_busy", {31'd0, busy}, 32'd1);
        @(negedge mdclk);
        check("rsv_c2_valid", {31'd0, rsp_valid}, 32'd0);
        check("rsv_c2_ready", {31'd0, req_ready}, 32'd1);

        // ---------------- req_valid held while busy ----------------
        start_req(2'b00, 8'h34, 8'h99, 1'b1);
        req_op    = 2'b01;
        req_addr  = 8'hFF;
        req_wdata = 8'h11;
        check("hold_c1_ready", {31'd0, req_ready}, 32'd0);
        check("hold_c1_mdwdi", {24'd0, mdwdi}, 32'h34);
        @(negedge mdclk);
        check("hold_c2_mdopc", {30'd0, mdopc}, 32'd1);
        check("hold_c2_mdwdi", {24'd0, mdwdi}, 32'h99);
        @(negedge mdclk);
        check("hold_c3_valid", {31'd0, rsp_valid}, 32'd1);
        req_valid = 1'b0;
        @(negedge mdclk);
        check("hold_c4_mdopc", {30'd0, mdopc}, 32'd0);
        @(negedge mdclk);
        check("hold_c5_busy", {31'd0, busy}, 32'd0);
        check("rdata_held", {24'd0, rsp_rdata}, 32'hC3);

        // ---------------- apply, lock after 100 cycles ----------------
        apply_run(100);
        check("apply_lock_lost", {31'd0, lock_lost}, 32'd0);

        // ---------------- lock drop in idle, then timeout ----------------
        pll_lock = 1'b0;
        repeat (4) @(negedge mdclk);
        check("idle_lock_lost", {31'd0, lock_lost}, 32'd1);
        apply_run(-1);
        check("timeout_lock_lost", {31'd0, lock_lost}, 32'd1);
        apply_run(5);
        check("recover_lock_lost", {31'd0, lock_lost}, 32'd0);
        // Lock is high entering apply and drops during RST: not a loss
        apply_run(3);
        check("apply_drop_no_lost", {31'd0, lock_lost}, 32'd0);

        // ---------------- reset during WR ----------------
        start_req(2'b00, 8'h21, 8'h43, 1'b0);
        @(negedge mdclk);
        check("rstwr_pre_mdopc", {30'd0, mdopc}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstwr_mdopc", {30'd0, mdopc}, 32'd0);
        check("rstwr_mdwdi", {24'd0, mdwdi}, 32'd0);
        check("rstwr_ready", {31'd0, req_ready}, 32'd0);
        @(negedge mdclk);
        reset = 1'b0;
        @(negedge mdclk);
        check("rstwr_rel_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        repeat (4) begin
            if (rsp_valid === 1'b1 || mdopc !== 2'b00) seen++;
            @(negedge mdclk);
        end
        check("rstwr_no_rsp", seen, 0);

        // ---------------- reset during RST ----------------
        start_req(2'b10, 8'h00, 8'h00, 1'b0);
        repeat (4) @(negedge mdclk);
        check("rstrst_pre_pll", {31'd0, pll_reset}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstrst_pll_reset", {31'd0, pll_reset}, 32'd0);
        check("rstrst_busy", {31'd0, busy}, 32'd0);
        @(negedge mdclk);
        reset = 1'b0;
        @(negedge mdclk);
        check("rstrst_rel_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        repeat (30) begin
            if (rsp_valid === 1'b1 || pll_reset === 1'b1) seen++;
            @(negedge mdclk);
        end
        check("rstrst_no_rsp", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
